adder_lock_hd_monitor: RTL and testbench
========================================

# adder_lock_hd_monitor

Synthesizable output-corruption monitor that sits directly downstream of the key-locked 32-bit ripple-carry adder. For each vector it recomputes the golden sum, XORs it with the locked adder's 33-bit result, and accumulates error statistics over a trial of N vectors. The statistics are mismatching-vector count, total output Hamming distance and worst-case per-vector Hamming distance. It quantifies the effect of a wrong key in hardware and replaces the per-vector `$monitor` dump.

## Interface
- DATA_W, 32, operand width; result width is DATA_W+1 (derived, not overridable)
- CNT_W, 16, width of vector-count and error-count registers
- HD_W, 24, width of Hamming-distance accumulator
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  begin a trial; sampled only in IDLE
- num_vec_i  in  CNT_W  vectors in trial; sampled with start_i
- vec_valid_i  in  1  operand/result triple valid
- vec_ready_o  out  1  monitor accepts a vector this cycle
- add1_i, add2_i  in  DATA_W  operands as driven into the locked adder
- result_i  in  DATA_W+1  locked adder output for those operands
- busy_o  out  1  state is not IDLE
- done_o  out  1  one-cycle pulse, statistics final
- vec_cnt_o  out  CNT_W  vectors accepted this trial
- err_cnt_o  out  CNT_W  vectors with result_i != golden
- hd_sum_o  out  HD_W  sum of per-vector Hamming distances
- hd_max_o  out  6  largest per-vector Hamming distance (0..33)

## Operation
- golden = {1'b0,add1_i} + {1'b0,add2_i}, 33-bit, carry-out in bit 32; diff = golden ^ result_i; hd = popcount(diff).
- FSM states IDLE, RUN, DRAIN, DONE.
- IDLE: start_i=1 latches num_vec_i and clears all four statistics. Next state is RUN if num_vec_i != 0, else DONE.
- RUN: vec_ready_o=1. A transfer occurs when vec_valid_i & vec_ready_o. Each transfer increments vec_cnt_o and loads diff into the stage-1 register. When the transfer makes vec_cnt_o equal the latched count, next state is DRAIN and vec_ready_o falls the following cycle.
- DRAIN: one cycle, the last stage-2 accumulate completes; then DONE.
- DONE: done_o=1 for exactly one cycle; then IDLE. Statistics hold until the next start_i.
- Stage 2 consumes a valid stage-1 entry. It adds hd to hd_sum_o, increments err_cnt_o if hd != 0, and sets hd_max_o = max(hd_max_o, hd).
- Saturation: err_cnt_o and hd_sum_o saturate at all-ones and never wrap.
- start_i is ignored outside IDLE. start_i and the DONE pulse never overlap, because start_i is only sampled in IDLE.
- vec_valid_i outside RUN is ignored; no transfer occurs.
- Reset mid-trial: state returns to IDLE, pipeline valid flags are cleared, all outputs are zeroed, and the partial trial is discarded.

## Timing
- Reset values are all zero: vec_ready_o, busy_o, done_o, vec_cnt_o, err_cnt_o, hd_sum_o and hd_max_o.
- start_i sampled at edge S makes busy_o=1 after S. vec_ready_o=1 after S, or done_o=1 after S when num_vec_i=0.
- A vector transferred at edge k is in stage 1 after k and in the statistics after edge k+1 (latency 2 edges).
- If the last transfer is at edge L: DRAIN holds during L..L+1, done_o=1 in the cycle after L+1, and busy_o=0 after L+2.
- Back-to-back transfers are sustained at 1 vector per cycle; gaps in vec_valid_i only delay completion.
- Minimum trial length for N vectors is N+3 cycles from start_i to return to IDLE.

## Structure
- Package adder_lock_pkg holds:
  - DATA_W, RES_W = DATA_W+1, and HD_MAX_W = 6
  - the state enum {IDLE, RUN, DRAIN, DONE}
  - the nominal key constant 64'hA87E0E812FE200DE, for benches only
- One sub-module, hd_popcount: purely combinational RES_W-bit popcount returning a 6-bit count. It is instantiated once between stage 1 and stage 2.
- The golden adder is inline `+` and must not reuse the locked adder netlist.

## Test plan
- Correct-key pass: N=4 with add1=FFFFFFFF, add2=00000001, result=1_00000000 plus three random matching triples. Expect err_cnt=0, hd_sum=0, hd_max=0, vec_cnt=4, and a single done_o pulse.
- Single-bit corruption: N=1 with add1=00000005, add2=00000003, result=0_00000009 (golden 0_00000008). Expect err_cnt=1, hd_sum=1, hd_max=1.
- Full corruption plus max tracking: N=3.
  - Vector 1: add1=0, add2=0, result=1_FFFFFFFF, giving hd 33.
  - Vectors 2 and 3: hd 2 and 0.
  - Expect err_cnt=2, hd_sum=35, hd_max=33 (6'h21).
- Zero-length trial: num_vec_i=0. Expect done_o in the cycle after start, vec_ready_o never high, and statistics 0.
- Handshake gaps and ignored start: N=5 with vec_valid_i toggling 1,0,1,1,0,1,1 and start_i pulsed mid-RUN. Expect exactly 5 transfers counted, the extra start ignored, and done_o 2 edges after the 5th transfer.
- Reset mid-trial and saturation:
  - Assert rst after 3 of 8 vectors. Expect all outputs 0 and busy_o=0 next cycle.
  - Then run CNT_W=4, N=15 all-mismatching with HD_W=4 and hd 33 each. Expect hd_sum=4'hF and err_cnt=15, with no wrap.

Source files
------------

// File: rtl/adder_lock_pkg.sv
// -----------------------------------------------------------------------------
// adder_lock_pkg
//
// Shared definitions for the key-locked adder corruption monitor.
//   DATA_W      operand width of the locked ripple-carry adder
//   RES_W       result width (operand width plus carry-out)
//   HD_MAX_W    width of a per-vector Hamming distance (holds 0..RES_W)
//   state_e     monitor trial FSM states
//   NOMINAL_KEY correct unlocking key, used only by benches
// -----------------------------------------------------------------------------
package adder_lock_pkg;

    localparam int DATA_W   = 32;
    localparam int RES_W    = DATA_W + 1;
    localparam int HD_MAX_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [63:0] NOMINAL_KEY = 64'hA87E0E812FE200DE;

endpackage

// File: rtl/hd_popcount.sv
// -----------------------------------------------------------------------------
// hd_popcount
//
// Purely combinational population count of a difference vector; the result is
// the Hamming distance between the golden and the locked adder results.
//   vec_i  in  W         difference vector (golden ^ locked result)
//   cnt_o  out HD_MAX_W  number of set bits in vec_i (0..W)
// -----------------------------------------------------------------------------
module hd_popcount
    import adder_lock_pkg::*;
#(
    parameter int W = RES_W
) (
    input  logic [W-1:0]        vec_i,
    output logic [HD_MAX_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < W; i++) begin
            cnt_o = cnt_o + {{(HD_MAX_W-1){1'b0}}, vec_i[i]};
        end
    end

endmodule

// File: rtl/adder_lock_hd_monitor.sv
// -----------------------------------------------------------------------------
// adder_lock_hd_monitor
//
// Output-corruption monitor placed downstream of the key-locked 32-bit adder.
// Every accepted vector has its golden sum recomputed with an inline adder
// (independent of the locked netlist); the XOR with the locked result is
// registered in stage 1, popcounted, and folded into trial statistics in
// stage 2. A trial covers num_vec_i vectors started by start_i in IDLE.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start_i         begin a trial (sampled only in IDLE)
//   num_vec_i       vectors in the trial, latched with start_i
//   vec_valid_i     operand/result triple valid
//   vec_ready_o     monitor accepts a vector this cycle (RUN state)
//   add1_i, add2_i  operands driven into the locked adder
//   result_i        locked adder output for those operands
//   busy_o          trial in progress (state not IDLE)
//   done_o          one-cycle pulse, statistics are final
//   vec_cnt_o       vectors accepted this trial
//   err_cnt_o       mismatching vectors (saturating)
//   hd_sum_o        total Hamming distance (saturating)
//   hd_max_o        worst per-vector Hamming distance
// -----------------------------------------------------------------------------
module adder_lock_hd_monitor
    import adder_lock_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int HD_W  = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [CNT_W-1:0]    num_vec_i,
    input  logic                vec_valid_i,
    output logic                vec_ready_o,
    input  logic [DATA_W-1:0]   add1_i,
    input  logic [DATA_W-1:0]   add2_i,
    input  logic [RES_W-1:0]    result_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_W-1:0]    vec_cnt_o,
    output logic [CNT_W-1:0]    err_cnt_o,
    output logic [HD_W-1:0]     hd_sum_o,
    output logic [HD_MAX_W-1:0] hd_max_o
);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Saturating accumulate of a per-vector distance into the HD sum. The sum
    // is formed one field wider than both operands so any overflow shows up
    // in the upper bits, even when HD_W is narrower than a single distance.
    function automatic logic [HD_W-1:0] sat_add_hd(input logic [HD_W-1:0]     acc,
                                                   input logic [HD_MAX_W-1:0] hd);
        logic [HD_W+HD_MAX_W-1:0] wide;
        wide = {{HD_MAX_W{1'b0}}, acc} + {{HD_W{1'b0}}, hd};
        if (|wide[HD_W+HD_MAX_W-1:HD_W]) begin
            return '1;
        end
        return wide[HD_W-1:0];
    endfunction

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      num_q, num_d;
    logic [CNT_W-1:0]      vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic [HD_W-1:0]       hd_sum_q, hd_sum_d;
    logic [HD_MAX_W-1:0]   hd_max_q, hd_max_d;
    logic                  vld_p1_q, vld_p1_d;
    logic [RES_W-1:0]      diff_p1_q;

    logic                  start_acc;
    logic                  xfer;
    logic [CNT_W-1:0]      cnt_inc;
    logic [RES_W-1:0]      golden;
    logic [RES_W-1:0]      diff;
    logic [HD_MAX_W-1:0]   hd_p1;

    assign start_acc = (state_q == IDLE) && start_i;
    assign xfer      = vec_valid_i && (state_q == RUN);
    assign cnt_inc   = vec_cnt_q + CNT_W'(1);

    // Stage 0: golden recompute on the incoming triple
    assign golden = {1'b0, add1_i} + {1'b0, add2_i};
    assign diff   = golden ^ result_i;

    // ---------------------------------------------------------------------
    // Trial FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (num_vec_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (xfer && (cnt_inc == num_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage 1 -> stage 2: distance of the registered difference
    hd_popcount #(
        .W (RES_W)
    ) u_popcount (
        .vec_i (diff_p1_q),
        .cnt_o (hd_p1)
    );

    // ---------------------------------------------------------------------
    // Counters and statistics next-state
    // ---------------------------------------------------------------------
    always_comb begin
        num_d     = num_q;
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        hd_sum_d  = hd_sum_q;
        hd_max_d  = hd_max_q;
        vld_p1_d  = xfer;

        if (start_acc) begin
            // No stage-1 entry can be pending in IDLE, so clearing wins.
            num_d     = num_vec_i;
            vec_cnt_d = '0;
            err_cnt_d = '0;
            hd_sum_d  = '0;
            hd_max_d  = '0;
        end else begin
            if (xfer) begin
                vec_cnt_d = cnt_inc;
            end
            if (vld_p1_q) begin
                if (hd_p1 != '0) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                end
                hd_sum_d = sat_add_hd(hd_sum_q, hd_p1);
                if (hd_p1 > hd_max_q) begin
                    hd_max_d = hd_p1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q     <= '0;
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            hd_sum_q  <= '0;
            hd_max_q  <= '0;
            vld_p1_q  <= 1'b0;
        end else begin
            num_q     <= num_d;
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
            hd_sum_q  <= hd_sum_d;
            hd_max_q  <= hd_max_d;
            vld_p1_q  <= vld_p1_d;
        end
    end

    // Stage 1: difference register; qualified by vld_p1_q, so no reset needed
    always_ff @(posedge clk) begin
        if (xfer) begin
            diff_p1_q <= diff;
        end
    end

    assign vec_ready_o = (state_q == RUN);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign vec_cnt_o   = vec_cnt_q;
    assign err_cnt_o   = err_cnt_q;
    assign hd_sum_o    = hd_sum_q;
    assign hd_max_o    = hd_max_q;

endmodule

// File: tb/tb_adder_lock_hd_monitor.sv
module tb_adder_lock_hd_monitor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num;
    logic        valid;
    logic [31:0] add1;
    logic [31:0] add2;
    logic [32:0] result;

    // Default-width instance
    logic        ready_b, busy_b, done_b;
    logic [15:0] vec_cnt_b, err_b;
    logic [23:0] hdsum_b;
    logic [5:0]  hdmax_b;

    // Narrow instance (CNT_W=4, HD_W=4) for saturation; runs in lockstep
    logic        ready_s, busy_s, done_s;
    logic [3:0]  vec_cnt_s, err_s;
    logic [3:0]  hdsum_s;
    logic [5:0]  hdmax_s;

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    int exp_q[$];

    adder_lock_hd_monitor dut_b (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .num_vec_i   (num),
        .vec_valid_i (valid),
        .vec_ready_o (ready_b),
        .add1_i      (add1),
        .add2_i      (add2),
        .result_i    (result),
        .busy_o      (busy_b),
        .done_o      (done_b),
        .vec_cnt_o   (vec_cnt_b),
        .err_cnt_o   (err_b),
        .hd_sum_o    (hdsum_b),
        .hd_max_o    (hdmax_b)
    );

    adder_lock_hd_monitor #(.CNT_W(4), .HD_W(4)) dut_s (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .num_vec_i   (num[3:0]),
        .vec_valid_i (valid),
        .vec_ready_o (ready_s),
        .add1_i      (add1),
        .add2_i      (add2),
        .result_i    (result),
        .busy_o      (busy_s),
        .done_o      (done_s),
        .vec_cnt_o   (vec_cnt_s),
        .err_cnt_o   (err_s),
        .hd_sum_o    (hdsum_s),
        .hd_max_o    (hdmax_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus; an accepted vector gets its expected
    // Hamming distance pushed onto the scoreboard.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [32:0] r);
        logic [32:0] g;
        valid  = v;
        add1   = a;
        add2   = b;
        result = r;
        if (v && ready_b) begin
            g = {1'b0, a} + {1'b0, b};
            exp_q.push_back($countones(g ^ r));
            xfers++;
        end
        tick();
        valid = 1'b0;
    endtask

    task automatic start_trial(input int n);
        start = 1'b1;
        num   = 16'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            if (done_b) seen = 1'b1;
            else begin
                tick();
                cycles++;
            end
        end
    endtask

    task automatic sb_drain(output int n, output int e, output int s, output int m);
        int h;
        n = 0; e = 0; s = 0; m = 0;
        while (exp_q.size() > 0) begin
            h = exp_q.pop_front();
            n++;
            if (h != 0) e++;
            s += h;
            if (h > m) m = h;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num = '0; valid = 1'b0;
        add1 = '0; add2 = '0; result = '0;
        tick(); tick();
        total++; if (ready_b !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", ready_b); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy_b); end
        total++; if (done_b !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", done_b); end
        total++; if (vec_cnt_b !== 16'd0) begin bad++; $display("FAIL rst_veccnt got=%0d exp=0", vec_cnt_b); end
        total++; if (err_b !== 16'd0) begin bad++; $display("FAIL rst_err got=%0d exp=0", err_b); end
        total++; if (hdsum_b !== 24'd0) begin bad++; $display("FAIL rst_hdsum got=%0d exp=0", hdsum_b); end
        total++; if (hdmax_b !== 6'd0) begin bad++; $display("FAIL rst_hdmax got=%0d exp=0", hdmax_b); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_correct_key();
        int n, e, s, m, cyc;
        bit seen;
        logic [31:0] a, b;
        start_trial(4);
        total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL ck_busy got=%0b exp=1", busy_b); end
        total++; if (ready_b !== 1'b1) begin bad++; $display("FAIL ck_ready got=%0b exp=1", ready_b); end
        drive(1'b1, 32'hFFFFFFFF, 32'h00000001, 33'h1_00000000);
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            drive(1'b1, a, b, {1'b0, a} + {1'b0, b});
        end
        total++; if (ready_b !== 1'b0) begin bad++; $display("FAIL ck_drain_ready got=%0b exp=0", ready_b); end
        wait_done(10, cyc, seen);
        total++; if (!seen || cyc != 1) begin bad++; $display("FAIL ck_done_lat got=%0d seen=%0b exp=1", cyc, seen); end
        sb_drain(n, e, s, m);
        total++; if (vec_cnt_b !== 16'(n)) begin bad++; $display("FAIL ck_veccnt got=%0d exp=%0d", vec_cnt_b, n); end
        total++; if (err_b !== 16'(e)) begin bad++; $display("FAIL ck_err got=%0d exp=%0d", err_b, e); end
        total++; if (hdsum_b !== 24'(s)) begin bad++; $display("FAIL ck_hdsum got=%0d exp=%0d", hdsum_b, s); end
        total++; if (hdmax_b !== 6'(m)) begin bad++; $display("FAIL ck_hdmax got=%0d exp=%0d", hdmax_b, m); end
        tick();
        total++; if (done_b !== 1'b0) begin bad++; $display("FAIL ck_done_pulse got=%0b exp=0", done_b); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL ck_idle_busy got=%0b exp=0", busy_b); end
    endtask

    task automatic test_single_bit();
        int n, e, s, m, cyc;
        bit seen;
        start_trial(1);
        drive(1'b1, 32'h00000005, 32'h00000003, 33'h0_00000009);
        wait_done(10, cyc, seen);
        total++; if (!seen) begin bad++; $display("FAIL sb_done_timeout got=%0d exp=done", cyc); end
        sb_drain(n, e, s, m);
        tick(); tick(); tick();
        total++; if (err_b !== 16'(e)) begin bad++; $display("FAIL sb_err got=%0d exp=%0d", err_b, e); end
        total++; if (hdsum_b !== 24'(s)) begin bad++; $display("FAIL sb_hdsum got=%0d exp=%0d", hdsum_b, s); end
        total++; if (hdmax_b !== 6'(m)) begin bad++; $display("FAIL sb_hdmax got=%0d exp=%0d", hdmax_b, m); end
    endtask

    task automatic test_full_corrupt();
        int n, e, s, m, cyc;
        bit seen;
        start_trial(3);
        drive(1'b1, 32'h0, 32'h0, 33'h1_FFFFFFFF);
        drive(1'b1, 32'h1, 32'h1, 33'h0_00000001);
        drive(1'b1, 32'h7, 32'h8, 33'h0_0000000F);
        wait_done(10, cyc, seen);
        total++; if (!seen) begin bad++; $display("FAIL fc_done_timeout got=%0d exp=done", cyc); end
        sb_drain(n, e, s, m);
        total++; if (err_b !== 16'd2) begin bad++; $display("FAIL fc_err got=%0d exp=2", err_b); end
        total++; if (hdsum_b !== 24'd35) begin bad++; $display("FAIL fc_hdsum got=%0d exp=35", hdsum_b); end
        total++; if (hdmax_b !== 6'h21) begin bad++; $display("FAIL fc_hdmax got=%0d exp=33", hdmax_b); end
        total++; if (hdsum_b !== 24'(s)) begin bad++; $display("FAIL fc_hdsum_sb got=%0d exp=%0d", hdsum_b, s); end
        tick();
    endtask

    task automatic test_zero_len();
        bit ready_seen;
        start_trial(0);
        ready_seen = ready_b;
        total++; if (done_b !== 1'b1) begin bad++; $display("FAIL zl_done got=%0b exp=1", done_b); end
        total++; if (vec_cnt_b !== 16'd0) begin bad++; $display("FAIL zl_veccnt got=%0d exp=0", vec_cnt_b); end
        total++; if (err_b !== 16'd0) begin bad++; $display("FAIL zl_err got=%0d exp=0", err_b); end
        total++; if (hdsum_b !== 24'd0) begin bad++; $display("FAIL zl_hdsum got=%0d exp=0", hdsum_b); end
        total++; if (hdmax_b !== 6'd0) begin bad++; $display("FAIL zl_hdmax got=%0d exp=0", hdmax_b); end
        tick();
        ready_seen = ready_seen | ready_b;
        total++; if (done_b !== 1'b0) begin bad++; $display("FAIL zl_done_pulse got=%0b exp=0", done_b); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL zl_busy got=%0b exp=0", busy_b); end
        total++; if (ready_seen !== 1'b0) begin bad++; $display("FAIL zl_ready got=%0b exp=0", ready_seen); end
    endtask

    task automatic test_gaps();
        int n, e, s, m, cyc;
        bit seen;
        logic [6:0]  pat;
        logic [31:0] a, b;
        logic [32:0] g, mask;
        pat   = 7'b1101101; // bit i drives cycle i: 1,0,1,1,0,1,1
        xfers = 0;
        start_trial(5);
        for (int i = 0; i < 7; i++) begin
            a = $urandom;
            b = $urandom;
            g = {1'b0, a} + {1'b0, b};
            mask = (i % 3 == 0) ? 33'h0 : (33'h1_00000000 | (33'h1 << (i * 4)));
            if (i == 2) begin
                start = 1'b1;
                num   = 16'd3;
            end
            drive(pat[i], a, b, g ^ mask);
            start = 1'b0;
        end
        total++; if (xfers != 5) begin bad++; $display("FAIL gp_xfers got=%0d exp=5", xfers); end
        total++; if (vec_cnt_b !== 16'd5) begin bad++; $display("FAIL gp_veccnt got=%0d exp=5", vec_cnt_b); end
        total++; if (ready_b !== 1'b0) begin bad++; $display("FAIL gp_ready got=%0b exp=0", ready_b); end
        wait_done(10, cyc, seen);
        total++; if (!seen || cyc != 1) begin bad++; $display("FAIL gp_done_lat got=%0d seen=%0b exp=1", cyc, seen); end
        sb_drain(n, e, s, m);
        total++; if (err_b !== 16'(e)) begin bad++; $display("FAIL gp_err got=%0d exp=%0d", err_b, e); end
        total++; if (hdsum_b !== 24'(s)) begin bad++; $display("FAIL gp_hdsum got=%0d exp=%0d", hdsum_b, s); end
        total++; if (hdmax_b !== 6'(m)) begin bad++; $display("FAIL gp_hdmax got=%0d exp=%0d", hdmax_b, m); end
        tick(); tick();
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL gp_no_restart got=%0b exp=0", busy_b); end
    endtask

    task automatic test_reset_mid();
        start_trial(8);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0, 32'h0, 33'h1_FFFFFFFF);
        end
        valid = 1'b1;
        rst   = 1'b1;
        tick();
        valid = 1'b0;
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL rm_busy got=%0b exp=0", busy_b); end
        total++; if (ready_b !== 1'b0) begin bad++; $display("FAIL rm_ready got=%0b exp=0", ready_b); end
        total++; if (vec_cnt_b !== 16'd0) begin bad++; $display("FAIL rm_veccnt got=%0d exp=0", vec_cnt_b); end
        total++; if (err_b !== 16'd0) begin bad++; $display("FAIL rm_err got=%0d exp=0", err_b); end
        total++; if (hdsum_b !== 24'd0) begin bad++; $display("FAIL rm_hdsum got=%0d exp=0", hdsum_b); end
        total++; if (hdmax_b !== 6'd0) begin bad++; $display("FAIL rm_hdmax got=%0d exp=0", hdmax_b); end
        total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL rm_busy_s got=%0b exp=0", busy_s); end
        rst = 1'b0;
        exp_q.delete();
        tick();
        total++; if (hdsum_b !== 24'd0) begin bad++; $display("FAIL rm_stale_pipe got=%0d exp=0", hdsum_b); end
    endtask

    task automatic test_saturation();
        int n, e, s, m, cyc;
        bit seen;
        start_trial(15);
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 32'h0, 32'h0, 33'h1_FFFFFFFF);
        end
        wait_done(10, cyc, seen);
        total++; if (!seen) begin bad++; $display("FAIL st_done_timeout got=%0d exp=done", cyc); end
        total++; if (done_s !== 1'b1) begin bad++; $display("FAIL st_done_s got=%0b exp=1", done_s); end
        sb_drain(n, e, s, m);
        total++; if (vec_cnt_s !== 4'(n)) begin bad++; $display("FAIL st_veccnt_s got=%0d exp=%0d", vec_cnt_s, n); end
        total++; if (err_s !== 4'((e > 15) ? 15 : e)) begin bad++; $display("FAIL st_err_s got=%0d exp=%0d", err_s, e); end
        total++; if (hdsum_s !== 4'((s > 15) ? 15 : s)) begin bad++; $display("FAIL st_hdsum_s got=%0d exp=%0d", hdsum_s, s); end
        total++; if (hdsum_s !== 4'hF) begin bad++; $display("FAIL st_hdsum_sat got=%0d exp=15", hdsum_s); end
        total++; if (hdmax_s !== 6'(m)) begin bad++; $display("FAIL st_hdmax_s got=%0d exp=%0d", hdmax_s, m); end
        total++; if (err_b !== 16'(e)) begin bad++; $display("FAIL st_err_b got=%0d exp=%0d", err_b, e); end
        total++; if (hdsum_b !== 24'(s)) begin bad++; $display("FAIL st_hdsum_b got=%0d exp=%0d", hdsum_b, s); end
        tick();
        total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL st_idle_s got=%0b exp=0", busy_s); end
    endtask

    initial begin
        test_reset();
        test_correct_key();
        test_single_bit();
        test_full_corrupt();
        test_zero_len();
        test_gaps();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
